// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencing controller: tracks in-flight destination registers,
// stalls decode on RAW hazards, freezes on data-memory busy, issues the IF/ID
// flush on redirects and walks HALT through a drain sequence.
module decode_hazard_ctrl #(
  parameter int TRACK_DEPTH  = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_readReg1,
  input  logic [2:0]       id_readReg2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_regWrite,
  input  logic [2:0]       id_writeRegSel,
  input  logic             id_flush,
  input  logic             id_halt,
  input  logic             mem_busy,
  output logic             stall_id,
  output logic             pc_hold,
  output logic             flush_ifid,
  output logic             halted,
  output logic [CNT_W-1:0] hazard_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam int             DCW        = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Scoreboard: entry 0 is ID/EX, entry TRACK_DEPTH-1 is the oldest tracked stage.
  logic [TRACK_DEPTH-1:0]      sb_valid_q, sb_valid_d;
  logic [TRACK_DEPTH-1:0][2:0] sb_reg_q,   sb_reg_d;
  logic [1:0]                  state_q,    state_d;
  logic [DCW-1:0]              drain_q,    drain_d;
  logic [CNT_W-1:0]            hcnt_q,     hcnt_d;

  logic hazard_s;
  logic issue_s;
  logic stall_s;

  // True when any valid in-flight entry targets register sel.
  function automatic logic sb_match(input logic [TRACK_DEPTH-1:0]      v,
                                    input logic [TRACK_DEPTH-1:0][2:0] r,
                                    input logic [2:0]                  sel);
    logic m;
    m = 1'b0;
    for (int i = 0; i < TRACK_DEPTH; i++) begin
      if (v[i] && (r[i] == sel)) begin
        m = 1'b1;
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

  // Hazard detection, issue qualification and the combinational stage controls.
  always_comb begin
    hazard_s = id_valid &
               ((id_use1 & sb_match(sb_valid_q, sb_reg_q, id_readReg1)) |
                (id_use2 & sb_match(sb_valid_q, sb_reg_q, id_readReg2)));
    issue_s  = id_valid & ~hazard_s & ~mem_busy & (state_q == ST_RUN);
    stall_s  = hazard_s | mem_busy | (state_q != ST_RUN);
  end

  // Scoreboard shift: an issuing writer enters at ID/EX, everything ages by one
  // stage per advancing cycle; a frozen pipeline holds every entry.
  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_reg_d   = sb_reg_q;
    if (!mem_busy) begin
      sb_valid_d[0] = issue_s & id_regWrite;
      sb_reg_d[0]   = id_writeRegSel;
      for (int i = 1; i < TRACK_DEPTH; i++) begin
        sb_valid_d[i] = sb_valid_q[i-1];
        sb_reg_d[i]   = sb_reg_q[i-1];
      end
    end else begin
      sb_valid_d = sb_valid_q;
      sb_reg_d   = sb_reg_q;
    end
  end

  // HALT sequencing: RUN -> DRAIN on an issued HALT, DRAIN counts advancing
  // cycles until the older instructions have retired, HALTED is sticky.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (issue_s && id_halt) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!mem_busy) begin
          drain_d = drain_q - DRAIN_ONE;
          if (drain_q == DRAIN_ONE) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        drain_d = {DCW{1'b0}};
      end
    endcase
  end

  // Saturating count of RAW-stall cycles; frozen cycles are not charged.
  always_comb begin
    hcnt_d = hcnt_q;
    if (hazard_s && !mem_busy && (hcnt_q != CNT_MAX)) begin
      hcnt_d = hcnt_q + CNT_ONE;
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // State registers with synchronous reset back to an empty, running pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid_q <= {TRACK_DEPTH{1'b0}};
      sb_reg_q   <= '0;
      state_q    <= ST_RUN;
      drain_q    <= {DCW{1'b0}};
      hcnt_q     <= {CNT_W{1'b0}};
    end else begin
      sb_valid_q <= sb_valid_d;
      sb_reg_q   <= sb_reg_d;
      state_q    <= state_d;
      drain_q    <= drain_d;
      hcnt_q     <= hcnt_d;
    end
  end

  assign stall_id   = stall_s;
  assign pc_hold    = stall_s;
  assign flush_ifid = issue_s & id_flush;
  assign halted     = (state_q == ST_HALTED);
  assign hazard_cnt = hcnt_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl. A second instance with a 4-bit
// counter shares the stimulus so counter saturation is reached quickly.
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_readReg1;
  logic [2:0]  id_readReg2;
  logic        id_use1;
  logic        id_use2;
  logic        id_regWrite;
  logic [2:0]  id_writeRegSel;
  logic        id_flush;
  logic        id_halt;
  logic        mem_busy;
  logic        stall_id;
  logic        pc_hold;
  logic        flush_ifid;
  logic        halted;
  logic [15:0] hazard_cnt;
  logic        s_stall_id;
  logic        s_pc_hold;
  logic        s_flush_ifid;
  logic        s_halted;
  logic [3:0]  s_hazard_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_readReg1(id_readReg1), .id_readReg2(id_readReg2),
    .id_use1(id_use1), .id_use2(id_use2), .id_regWrite(id_regWrite),
    .id_writeRegSel(id_writeRegSel), .id_flush(id_flush), .id_halt(id_halt),
    .mem_busy(mem_busy), .stall_id(stall_id), .pc_hold(pc_hold),
    .flush_ifid(flush_ifid), .halted(halted), .hazard_cnt(hazard_cnt)
  );

  decode_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_readReg1(id_readReg1), .id_readReg2(id_readReg2),
    .id_use1(id_use1), .id_use2(id_use2), .id_regWrite(id_regWrite),
    .id_writeRegSel(id_writeRegSel), .id_flush(id_flush), .id_halt(id_halt),
    .mem_busy(mem_busy), .stall_id(s_stall_id), .pc_hold(s_pc_hold),
    .flush_ifid(s_flush_ifid), .halted(s_halted), .hazard_cnt(s_hazard_cnt)
  );

  task automatic drive(input logic v, input logic [2:0] r1, input logic [2:0] r2,
                       input logic u1, input logic u2, input logic rw,
                       input logic [2:0] ws, input logic fl, input logic hl,
                       input logic mb);
    id_valid = v; id_readReg1 = r1; id_readReg2 = r2; id_use1 = u1; id_use2 = u2;
    id_regWrite = rw; id_writeRegSel = ws; id_flush = fl; id_halt = hl; mem_busy = mb;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", stall_id); end
    n_cmp++; if (pc_hold !== 1'b0) begin n_bad++; $display("FAIL rst_pc_hold got %b exp 0", pc_hold); end
    n_cmp++; if (flush_ifid !== 1'b0) begin n_bad++; $display("FAIL rst_flush got %b exp 0", flush_ifid); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted got %b exp 0", halted); end
    n_cmp++; if (hazard_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt got %0d exp 0", hazard_cnt); end
    n_cmp++; if ({s_stall_id, s_pc_hold, s_flush_ifid, s_halted, s_hazard_cnt} !== 8'h00) begin
      n_bad++; $display("FAIL rst_sat_inst got %b%b%b%b %h exp all 0", s_stall_id, s_pc_hold, s_flush_ifid, s_halted, s_hazard_cnt);
    end
  endtask

  task automatic test_raw();
    do_reset();
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    settle();
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL raw_writer_stall got %b exp 0", stall_id); end
    tick();
    drive(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_cmp++; if ({stall_id, pc_hold} !== 2'b11) begin n_bad++; $display("FAIL raw_stall1 got %b%b exp 11", stall_id, pc_hold); end
    tick();
    settle();
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL raw_stall2 got %b exp 1", stall_id); end
    tick();
    settle();
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL raw_release got %b exp 0", stall_id); end
    n_cmp++; if (hazard_cnt !== 16'd2) begin n_bad++; $display("FAIL raw_cnt got %0d exp 2", hazard_cnt); end
    tick();
    // Invalid writer must not leave an entry; invalid reader must not stall.
    drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL bubble_no_entry got %b exp 0", stall_id); end
    tick();
    idle();
  endtask

  task automatic test_busy();
    do_reset();
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL busy_stall[%0d] got %b exp 1", i, stall_id); end
      tick();
    end
    n_cmp++; if (hazard_cnt !== 16'd0) begin n_bad++; $display("FAIL busy_cnt_frozen got %0d exp 0", hazard_cnt); end
    mem_busy = 1'b0;
    settle();
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL busy_held_hz1 got %b exp 1", stall_id); end
    tick();
    settle();
    n_cmp++; if (stall_id !== 1'b1) begin n_bad++; $display("FAIL busy_held_hz2 got %b exp 1", stall_id); end
    tick();
    settle();
    n_cmp++; if (stall_id !== 1'b0) begin n_bad++; $display("FAIL busy_release got %b exp 0", stall_id); end
    n_cmp++; if (hazard_cnt !== 16'd2) begin n_bad++; $display("FAIL busy_cnt got %0d exp 2", hazard_cnt); end
    tick();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    settle();
    n_cmp++; if ({stall_id, flush_ifid} !== 2'b10) begin n_bad++; $display("FAIL flush_hazard got %b%b exp 10", stall_id, flush_ifid); end
    tick();
    settle();
    n_cmp++; if ({stall_id, flush_ifid} !== 2'b01) begin n_bad++; $display("FAIL flush_issue got %b%b exp 01", stall_id, flush_ifid); end
    tick();
    idle();
    settle();
    n_cmp++; if (flush_ifid !== 1'b0) begin n_bad++; $display("FAIL flush_one_cycle got %b exp 0", flush_ifid); end
    n_cmp++; if (hazard_cnt !== 16'd1) begin n_bad++; $display("FAIL flush_cnt got %0d exp 1", hazard_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    settle();
    n_cmp++; if ({stall_id, flush_ifid} !== 2'b01) begin n_bad++; $display("FAIL halt_issue got %b%b exp 01", stall_id, flush_ifid); end
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if ({stall_id, halted} !== 2'b10) begin n_bad++; $display("FAIL halt_drain[%0d] got %b%b exp 10", i, stall_id, halted); end
      tick();
    end
    settle();
    n_cmp++; if ({stall_id, halted} !== 2'b11) begin n_bad++; $display("FAIL halt_done got %b%b exp 11", stall_id, halted); end
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    settle();
    n_cmp++; if ({stall_id, halted, flush_ifid} !== 3'b110) begin n_bad++; $display("FAIL halt_sticky got %b%b%b exp 110", stall_id, halted, flush_ifid); end
    tick();
    do_reset();
    settle();
    n_cmp++; if ({stall_id, halted} !== 2'b00) begin n_bad++; $display("FAIL halt_cleared got %b%b exp 00", stall_id, halted); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      if (k == 6) begin
        n_cmp++; if (s_hazard_cnt !== 4'd14) begin n_bad++; $display("FAIL sat_mid got %0d exp 14", s_hazard_cnt); end
      end
    end
    idle();
    settle();
    n_cmp++; if (hazard_cnt !== 16'd20) begin n_bad++; $display("FAIL sat_wide_cnt got %0d exp 20", hazard_cnt); end
    n_cmp++; if (s_hazard_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_no_wrap got %0d exp 15", s_hazard_cnt); end
  endtask

  task automatic test_rst_in_drain();
    do_reset();
    // HALT that also writes r3 so an entry is in flight during DRAIN.
    drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    settle();
    n_cmp++; if ({stall_id, halted} !== 2'b10) begin n_bad++; $display("FAIL drain_state got %b%b exp 10", stall_id, halted); end
    // Busy holds the r3 entry, so only the reset can clear it.
    rst = 1'b1;
    mem_busy = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    settle();
    n_cmp++; if ({stall_id, pc_hold, halted} !== 3'b000) begin n_bad++; $display("FAIL drain_rst got %b%b%b exp 000", stall_id, pc_hold, halted); end
    n_cmp++; if (hazard_cnt !== 16'd0) begin n_bad++; $display("FAIL drain_rst_cnt got %0d exp 0", hazard_cnt); end
    tick();
    idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    test_reset();
    test_raw();
    test_busy();
    test_flush();
    test_halt();
    test_saturation();
    test_rst_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
